// File: rtl/rf_write_arbiter_if.sv
// Bundle of writeback-source handshakes, claim port, hazard status and the
// register file write port shared by rf_write_arbiter and its users.
interface rf_write_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NREG   = 16
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              claim_valid;
  logic [ADDR_W-1:0] claim_reg;
  logic [NREG-1:0]   busy;
  logic              claim_err;
  logic              WriteReg;
  logic [ADDR_W-1:0] DstReg;
  logic [DATA_W-1:0] DstData;

  // Arbiter side
  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  mem_valid, mem_reg, mem_data,
    input  claim_valid, claim_reg,
    output alu_ready, mem_ready, busy, claim_err,
    output WriteReg, DstReg, DstData
  );

  // Producer / consumer side
  modport master (
    output alu_valid, alu_reg, alu_data,
    output mem_valid, mem_reg, mem_data,
    output claim_valid, claim_reg,
    input  alu_ready, mem_ready, busy, claim_err,
    input  WriteReg, DstReg, DstData
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single register-file write port between the
// ALU writeback path and late-returning loads. Each source feeds a small
// FIFO; a round-robin arbiter pops one head per cycle into registered write
// port outputs. A 2-bit pending-write counter per register drives busy[].
// Optional feature macro: RF_ZERO_REG_EN (register 0 hardwired to zero).
module rf_write_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int NREG       = 16,
  parameter int FIFO_DEPTH = 2
) (
  input logic              clk,
  input logic              rst,
  rf_write_arbiter_if.slave bus
);

`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  // Source index 0 = ALU, 1 = memory loads
  logic [1:0]       w_in_valid;
  logic [ENT_W-1:0] w_in_entry [2];
  logic [ENT_W-1:0] w_head     [2];
  logic [1:0]       w_ready;
  logic [1:0]       w_nonempty;
  logic [1:0]       w_pop;

  assign w_in_valid    = {bus.mem_valid, bus.alu_valid};
  assign w_in_entry[0] = {bus.alu_reg, bus.alu_data};
  assign w_in_entry[1] = {bus.mem_reg, bus.mem_data};
  assign bus.alu_ready = w_ready[0];
  assign bus.mem_ready = w_ready[1];

  genvar gi;

  generate
    for (gi = 0; gi < 2; gi++) begin : fifo_g
      logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
      logic [PTR_W-1:0] r_wr_ptr;
      logic [PTR_W-1:0] r_rd_ptr;
      logic [CNT_W-1:0] r_count;
      logic             w_push;

      // ready is purely "not full": a pop this cycle only frees the slot for
      // the next cycle, and ready is forced low while reset is asserted.
      assign w_ready[gi]    = !rst && (r_count != CNT_W'(FIFO_DEPTH));
      assign w_nonempty[gi] = (r_count != '0);
      assign w_push         = w_in_valid[gi] && w_ready[gi];
      assign w_head[gi]     = r_mem[r_rd_ptr];

      // Storage needs no reset: the count alone decides what is valid
      always_ff @(posedge clk) begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= w_in_entry[gi];
        end
      end

      // Pointer and occupancy bookkeeping
      always_ff @(posedge clk) begin
        if (rst) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
          end
          if (w_pop[gi]) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
          end
          case ({w_push, w_pop[gi]})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
          endcase
        end
      end
    end
  endgenerate

  // Round-robin pointer: 1 means the memory source won the last grant
  logic              r_last_mem;
  logic              w_grant_alu;
  logic              w_grant_mem;
  logic              w_issue;
  logic [ENT_W-1:0]  w_sel_entry;
  logic [ADDR_W-1:0] w_sel_reg;
  logic [DATA_W-1:0] w_sel_data;
  logic              r_write;
  logic [ADDR_W-1:0] r_dst_reg;
  logic [DATA_W-1:0] r_dst_data;

  assign w_grant_alu = w_nonempty[0] && (!w_nonempty[1] || r_last_mem);
  assign w_grant_mem = w_nonempty[1] && !w_grant_alu;
  assign w_pop       = {w_grant_mem, w_grant_alu};
  assign w_sel_entry = w_grant_mem ? w_head[1] : w_head[0];
  assign w_sel_reg   = w_sel_entry[ENT_W-1:DATA_W];
  assign w_sel_data  = w_sel_entry[DATA_W-1:0];
  // A granted slot aimed at the hardwired zero register is popped but not written
  assign w_issue     = (w_grant_alu || w_grant_mem) && !(ZERO_REG && (w_sel_reg == '0));

  // Grant bookkeeping and the registered write port; index/data hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_mem <= 1'b1;
      r_write    <= 1'b0;
      r_dst_reg  <= '0;
      r_dst_data <= '0;
    end else begin
      if (w_grant_alu || w_grant_mem) begin
        r_last_mem <= w_grant_mem;
      end
      r_write <= w_issue;
      if (w_issue) begin
        r_dst_reg  <= w_sel_reg;
        r_dst_data <= w_sel_data;
      end
    end
  end

  assign bus.WriteReg = r_write;
  assign bus.DstReg   = r_dst_reg;
  assign bus.DstData  = r_dst_data;

  // Pending-write scoreboard
  logic [NREG-1:0] w_busy;
  logic [NREG-1:0] w_sat_claim;
  logic            r_claim_err;

  generate
    for (gi = 0; gi < NREG; gi++) begin : sb_g
      if (ZERO_REG && (gi == 0)) begin : zero_g
        assign w_busy[gi]      = 1'b0;
        assign w_sat_claim[gi] = 1'b0;
      end else begin : cnt_g
        logic [1:0] r_cnt;
        logic       w_inc;
        logic       w_dec;

        assign w_inc           = bus.claim_valid && (bus.claim_reg == ADDR_W'(gi));
        assign w_dec           = w_issue && (w_sel_reg == ADDR_W'(gi));
        assign w_sat_claim[gi] = w_inc && !w_dec && (r_cnt == 2'd3);
        assign w_busy[gi]      = (r_cnt != 2'd0);

        // Saturating counter; claim and write on the same register cancel
        always_ff @(posedge clk) begin
          if (rst) begin
            r_cnt <= 2'd0;
          end else if (w_inc && !w_dec) begin
            if (r_cnt != 2'd3) begin
              r_cnt <= r_cnt + 2'd1;
            end
          end else if (w_dec && !w_inc) begin
            if (r_cnt != 2'd0) begin
              r_cnt <= r_cnt - 2'd1;
            end
          end
        end
      end
    end
  endgenerate

  // Sticky error: any claim that hit a saturated counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_claim_err <= 1'b0;
    end else begin
      r_claim_err <= r_claim_err || (|w_sat_claim);
    end
  end

  assign bus.busy      = w_busy;
  assign bus.claim_err = r_claim_err;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: the driver runs a queue-based
// reference model and pushes each expected write (with the edge it is due
// on) into a queue; a monitor on the falling edge pops and compares.
module tb_rf_write_arbiter;
  localparam int DEPTH = 2;
`ifdef RF_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  r;
    logic [15:0] d;
  } entry_t;

  typedef struct packed {
    int     due;
    entry_t e;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   edge_cnt;

  entry_t aq[$];
  entry_t mq[$];
  exp_t   expq[$];
  int     cnt_m [16];
  bit     err_m;
  bit     last_mem_m;

  rf_write_arbiter_if #(.DATA_W(16), .ADDR_W(4), .NREG(16)) bus_if ();

  rf_write_arbiter #(.DATA_W(16), .ADDR_W(4), .NREG(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: a write is either due on this edge (and must match) or must not appear
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (expq.size() > 0 && expq[0].due == edge_cnt) begin
        x = expq.pop_front();
        check("write_en", {31'd0, bus_if.WriteReg}, 32'd1);
        check("dst_reg", {28'd0, bus_if.DstReg}, {28'd0, x.e.r});
        check("dst_data", {16'd0, bus_if.DstData}, {16'd0, x.e.d});
        $display("write reg=%0d data=%h expected reg=%0d data=%h", bus_if.DstReg, bus_if.DstData, x.e.r, x.e.d);
      end else if (edge_cnt > 0) begin
        check("write_idle", {31'd0, bus_if.WriteReg}, 32'd0);
      end
    end
  end

  // One clock of stimulus: drive, check status outputs against the model,
  // advance the model to the coming edge, then wait for that edge.
  task automatic step(input bit r, input bit av, input logic [3:0] ar, input logic [15:0] ad,
                      input bit mv, input logic [3:0] mr, input logic [15:0] md,
                      input bit cv, input logic [3:0] cr, output bit acc_a, output bit acc_m);
    logic [15:0] bm;
    entry_t e;
    int g;
    int n;
    bit issue;
    rst = r;
    bus_if.alu_valid = av; bus_if.alu_reg = ar; bus_if.alu_data = ad;
    bus_if.mem_valid = mv; bus_if.mem_reg = mr; bus_if.mem_data = md;
    bus_if.claim_valid = cv; bus_if.claim_reg = cr;
    #1;
    for (int i = 0; i < 16; i++) bm[i] = (cnt_m[i] != 0);
    check("alu_ready", {31'd0, bus_if.alu_ready}, {31'd0, !r && aq.size() < DEPTH});
    check("mem_ready", {31'd0, bus_if.mem_ready}, {31'd0, !r && mq.size() < DEPTH});
    check("busy", {16'd0, bus_if.busy}, {16'd0, bm});
    check("claim_err", {31'd0, bus_if.claim_err}, {31'd0, err_m});
    acc_a = 1'b0;
    acc_m = 1'b0;
    if (r) begin
      aq.delete();
      mq.delete();
      for (int i = 0; i < 16; i++) cnt_m[i] = 0;
      err_m = 1'b0;
      last_mem_m = 1'b1;
    end else begin
      acc_a = av && (aq.size() < DEPTH);
      acc_m = mv && (mq.size() < DEPTH);
      g = -1;
      if (aq.size() > 0 && mq.size() > 0) g = last_mem_m ? 0 : 1;
      else if (aq.size() > 0) g = 0;
      else if (mq.size() > 0) g = 1;
      issue = 1'b0;
      e = '0;
      if (g == 0) begin e = aq.pop_front(); last_mem_m = 1'b0; end
      if (g == 1) begin e = mq.pop_front(); last_mem_m = 1'b1; end
      if (g >= 0 && !(ZERO && e.r == 4'd0)) begin
        issue = 1'b1;
        expq.push_back('{due: edge_cnt + 1, e: e});
      end
      for (int i = 0; i < 16; i++) begin
        n = cnt_m[i];
        if (cv && cr == 4'(i) && !(ZERO && i == 0)) n = n + 1;
        if (issue && e.r == 4'(i)) n = n - 1;
        if (n > 3) err_m = 1'b1;
        else if (n >= 0) cnt_m[i] = n;
      end
      if (acc_a) aq.push_back('{r: ar, d: ad});
      if (acc_m) mq.push_back('{r: mr, d: md});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    bit a, m;
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, a, m);
  endtask

  task automatic reset_checks();
    check("rst_write", {31'd0, bus_if.WriteReg}, 32'd0);
    check("rst_dstreg", {28'd0, bus_if.DstReg}, 32'd0);
    check("rst_dstdata", {16'd0, bus_if.DstData}, 32'd0);
    check("rst_busy", {16'd0, bus_if.busy}, 32'd0);
    check("rst_err", {31'd0, bus_if.claim_err}, 32'd0);
  endtask

  initial begin
    bit a, m;
    bit av, mv, cv;
    logic [3:0]  ar, mr, cr;
    logic [15:0] ad, md;
    int na, nm, guard;
    total = 0; bad = 0; edge_cnt = 0;
    rst = 1'b1;
    bus_if.alu_valid = 0; bus_if.alu_reg = 0; bus_if.alu_data = 0;
    bus_if.mem_valid = 0; bus_if.mem_reg = 0; bus_if.mem_data = 0;
    bus_if.claim_valid = 0; bus_if.claim_reg = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, a, m);
    reset_checks();

    // Single ALU write
    step(0, 1, 4'd3, 16'hBEEF, 0, 0, 0, 0, 0, a, m);
    idle(4);

    // Both sources every cycle: grants alternate starting with ALU
    na = 0; nm = 0; guard = 0;
    while ((na < 6 || nm < 6) && guard < 60) begin
      step(0, na < 6, 4'd1, 16'hA000 + 16'(na), nm < 6, 4'd2, 16'hB000 + 16'(nm), 0, 0, a, m);
      na += int'(a); nm += int'(m); guard++;
    end
    check("burst_done", guard < 60, 1);
    idle(4);

    // ALU only, three back-to-back requests
    na = 0; guard = 0;
    while (na < 3 && guard < 30) begin
      step(0, 1, 4'd4, 16'hC000 + 16'(na), 0, 0, 0, 0, 0, a, m);
      na += int'(a); guard++;
    end
    idle(4);

    // Two claims on reg 5, then two writes; then claim while a write to 5 issues
    step(0, 0, 0, 0, 0, 0, 0, 1, 4'd5, a, m);
    step(0, 0, 0, 0, 0, 0, 0, 1, 4'd5, a, m);
    step(0, 1, 4'd5, 16'h0505, 0, 0, 0, 0, 0, a, m);
    step(0, 0, 0, 0, 1, 4'd5, 16'h5555, 0, 0, a, m);
    idle(4);
    step(0, 0, 0, 0, 0, 0, 0, 1, 4'd5, a, m);
    step(0, 1, 4'd5, 16'h1234, 0, 0, 0, 0, 0, a, m);
    step(0, 0, 0, 0, 0, 0, 0, 1, 4'd5, a, m);
    idle(4);

    // Saturate reg 7, then reset mid-operation
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 4'd7, a, m);
    step(0, 1, 4'd9, 16'h9999, 1, 4'd8, 16'h8888, 0, 0, a, m);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, a, m);
    reset_checks();
    idle(3);

    // Register 0 traffic
    step(0, 0, 0, 0, 0, 0, 0, 1, 4'd0, a, m);
    step(0, 1, 4'd0, 16'h0F0F, 0, 0, 0, 0, 0, a, m);
    idle(4);

    // Randomised traffic; pending requests hold their payload until accepted
    av = 0; mv = 0; ar = 0; mr = 0; ad = 0; md = 0; a = 0; m = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!(av && !a)) begin
        av = $urandom_range(0, 99) < 55;
        ar = 4'($urandom_range(0, 15));
        ad = 16'($urandom);
      end
      if (!(mv && !m)) begin
        mv = $urandom_range(0, 99) < 45;
        mr = 4'($urandom_range(0, 15));
        md = 16'($urandom);
      end
      cv = $urandom_range(0, 99) < 25;
      cr = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) begin
        step(1, av, ar, ad, mv, mr, md, cv, cr, a, m);
        av = 0; mv = 0;
      end else begin
        step(0, av, ar, ad, mv, mr, md, cv, cr, a, m);
      end
    end
    idle(6);
    check("drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
